// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: direct-mapped tag+valid lookup/fill sequencer; define CACHE_STATS_EN for hit/miss counters
module cache_lookup_ctrl #(
  parameter int INDEX_W = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [31:0] resp_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  output logic        busy
);
  localparam int TAG_W = 32 - INDEX_W;
  typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS, FILL, RESP} state_t;
  state_t               r_state;
  logic [INDEX_W:0]     r_cnt;
  logic [31:0]          r_addr;
  logic                 r_hit;
  logic [TAG_W:0]       r_mem [2**INDEX_W];
  logic [TAG_W:0]       r_rd;
  logic [INDEX_W:0]     w_cnt_nx;
  logic                 w_we;
  logic [INDEX_W-1:0]   w_widx;
  logic [TAG_W:0]       w_wdata;
  logic                 w_tag_hit;
  // One write port shared by the INIT clear sweep and the FILL update
  assign w_cnt_nx  = r_cnt + 1'b1;
  assign w_we      = (r_state == INIT && !rst) || r_state == FILL;
  assign w_widx    = r_state == INIT ? r_cnt[INDEX_W-1:0] : r_addr[INDEX_W-1:0];
  assign w_wdata   = r_state == INIT ? '0 : {r_addr[31:INDEX_W], 1'b1};
  assign w_tag_hit = r_rd[0] && r_rd[TAG_W:1] == r_addr[31:INDEX_W];
  assign req_ready  = r_state == IDLE;
  assign busy       = r_state != IDLE;
  assign resp_valid = r_state == RESP;
  assign resp_hit   = resp_valid && r_hit;
  assign resp_addr  = resp_valid ? r_addr : '0;
  assign mem_req    = r_state == MISS;
  assign mem_addr   = mem_req ? r_addr : '0;
  // Entry is read on the accept edge so LOOKUP compares from a registered value
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
    if (r_state == IDLE) r_rd <= r_mem[req_addr[INDEX_W-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt   <= w_cnt_nx;
          r_state <= w_cnt_nx[INDEX_W] ? IDLE : INIT;
        end
        IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          r_hit   <= w_tag_hit;
          r_state <= w_tag_hit ? RESP : MISS;
        end
        MISS:    if (mem_ack) r_state <= FILL;
        FILL:    r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= INIT;
      endcase
    end
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == RESP) begin
      hit_cnt  <= hit_cnt + {31'b0, r_hit};
      miss_cnt <= miss_cnt + {31'b0, !r_hit};
    end
  end
`endif
endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// tb_cache_lookup_ctrl: directed vector bench for cache_lookup_ctrl at INDEX_W=4
module tb_cache_lookup_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        mem_ack = 1'b0;
  logic        req_ready, resp_valid, resp_hit, mem_req, busy;
  logic [31:0] resp_addr, mem_addr;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int checks = 0;
  int errors = 0;

  cache_lookup_ctrl #(.INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_addr(resp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
`ifdef CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    int          dly;
    logic        hold;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic chk_stats(input logic [31:0] h, input logic [31:0] m);
`ifdef CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, h);
    chk("miss_cnt", miss_cnt, m);
`endif
  endtask

  task automatic sweep_chk();
    for (int i = 0; i < 16; i++) begin
      chk("sweep_state", 32'({busy, req_ready, mem_req, resp_valid}), 32'h8);
      @(negedge clk);
    end
    chk("sweep_done", 32'({busy, req_ready}), 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", 32'({busy, req_ready, resp_valid, resp_hit, mem_req}), 32'h10);
    chk("rst_resp_addr", resp_addr, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    sweep_chk();
  endtask

  task automatic run(input vec_t t);
    chk("idle_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_addr  = t.addr;
    @(negedge clk);
    req_valid = t.hold;
    chk("lookup", 32'({busy, req_ready, mem_req, resp_valid}), 32'h8);
    @(negedge clk);
    if (!t.hit) begin
      for (int i = 0; i < t.dly; i++) begin
        chk("miss_wait", 32'({mem_req, resp_valid}), 32'h2);
        chk("miss_addr", mem_addr, t.addr);
        @(negedge clk);
      end
      chk("miss_req", 32'({mem_req, resp_valid}), 32'h2);
      chk("miss_addr", mem_addr, t.addr);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("fill", 32'({mem_req, resp_valid, req_ready}), 32'h0);
      @(negedge clk);
    end
    chk("resp", 32'({resp_valid, resp_hit, mem_req}), 32'({1'b1, t.hit, 1'b0}));
    chk("resp_addr", resp_addr, t.addr);
    @(negedge clk);
    req_valid = 1'b0;
    chk("back_idle", 32'({resp_valid, req_ready, busy}), 32'h2);
  endtask

  initial begin
    v[0] = '{32'h0000_1235, 1'b0, 3, 1'b0};
    v[1] = '{32'h0000_1235, 1'b1, 0, 1'b1};
    v[2] = '{32'h0000_2235, 1'b0, 0, 1'b0};
    v[3] = '{32'h0000_1235, 1'b0, 1, 1'b1};
    v[4] = '{32'h0000_1235, 1'b1, 0, 1'b0};
    v[5] = '{32'h0000_000F, 1'b0, 2, 1'b0};
    v[6] = '{32'h0000_000F, 1'b1, 0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run(v[i]);
      if (i == 3) chk_stats(32'd1, 32'd3);
    end
    chk_stats(32'd3, 32'd4);
    req_valid = 1'b1;
    req_addr  = 32'h0000_3235;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midmiss_req", 32'(mem_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midmiss_drop", 32'({mem_req, resp_valid, busy, req_ready}), 32'h2);
    chk_stats(32'd0, 32'd0);
    sweep_chk();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack", 32'({busy, req_ready, mem_req, resp_valid}), 32'h4);
    run('{32'h0000_1235, 1'b0, 1, 1'b0});
    chk_stats(32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
